signal_flip_axil_slave: RTL and testbench
=========================================

SIGNAL_FLIP_AXIL_SLAVE -- requirements
Module: signal_flip_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 x 32-bit registers.
REQ-003 SHALL have port ACLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports AWADDR in 4, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1: write address channel.
REQ-006 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-008 SHALL have ports ARADDR in 4, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1: read address channel.
REQ-009 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
REQ-010 SHALL have port flip_out  output  32  PATTERN or its bitwise inverse, per phase.
REQ-011 SHALL have port flip_phase  output  1  current phase; 0 = PATTERN, 1 = ~PATTERN.

Function
REQ-012 SHALL decode registers from address bits [3:2]: 0 CTRL (bit0 = enable), 1 PERIOD, 2 PATTERN, 3 SCRATCH; bits [1:0] ignored.
REQ-013 SHALL make all 32 bits of all four registers read/write, so a write is always read back unchanged.
REQ-014 SHALL accept AW and W independently: AWREADY high while no address is latched and BVALID low; WREADY likewise for data.
REQ-015 SHALL deassert AWREADY (WREADY) the cycle after its handshake until the write completes.
REQ-016 SHALL perform the register write in the cycle where both address and data are held, and assert BVALID with BRESP=2'b00 the following cycle.
REQ-017 SHALL hold BVALID until BVALID&&BREADY, then clear the latches; AWREADY/WREADY reassert the next cycle.
REQ-018 SHALL apply WSTRB per byte; WSTRB=0 completes the handshake with no register change.
REQ-019 SHALL assert ARREADY whenever RVALID is low; on ARVALID&&ARREADY, RVALID=1 next cycle with RDATA = addressed register and RRESP=2'b00.
REQ-020 SHALL hold RDATA/RVALID stable until RVALID&&RREADY; ARREADY low meanwhile.
REQ-021 SHALL return the pre-write value when a read is sampled in the same cycle a write updates that register.
REQ-022 SHALL keep a 32-bit counter cnt: CTRL[0]=1 -> increments each cycle; when cnt==PERIOD, cnt<=0 and flip_phase toggles.
REQ-023 SHALL, with PERIOD=0 and enable=1, toggle flip_phase every cycle.
REQ-024 SHALL, while CTRL[0]=0, hold cnt=0 and flip_phase=0.
REQ-025 SHALL clear cnt to 0 on any write to PERIOD and keep flip_phase.
REQ-026 SHALL register flip_out = flip_phase ? ~PATTERN : PATTERN, updated the cycle after flip_phase or PATTERN changes.

Reset
REQ-027 SHALL, on ARESETN low, immediately force all registers, cnt, flip_phase, flip_out, BVALID, RVALID, RDATA, BRESP, RRESP to 0, AWREADY/WREADY/ARREADY to 0, and clear all latches.
REQ-028 SHALL assert AWREADY, WREADY, ARREADY the first rising edge after ARESETN goes high.
REQ-029 SHALL discard any transaction in flight when reset asserts; no BVALID/RVALID is issued for it.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read each -> RDATA 0x1,0x2,0x3,0x4, all BRESP/RRESP 0.
REQ-031 W driven 3 cycles before AW, BREADY held low 5 cycles -> write occurs once, BVALID held stable, AWREADY/WREADY stay low until B handshake.
REQ-032 WSTRB=4'b0010, WDATA=0xAABBCCDD to SCRATCH=0x11223344 -> readback 0x1122CC44.
REQ-033 PATTERN=0x0000FFFF, PERIOD=3, CTRL=1 -> flip_out alternates 0x0000FFFF/0xFFFF0000 every 4 cycles; CTRL=0 -> flip_out=0x0000FFFF, phase 0.
REQ-034 Read PATTERN sampled same cycle as write 0x5 over 0x9 -> RDATA 0x9; next read 0x5.
REQ-035 ARESETN pulsed low with AW accepted and W pending -> no BVALID; all registers read 0 after release.

Source files
------------

// File: rtl/signal_flip_axil_slave_if.sv
// AXI4-Lite bus bundle for the signal_flip slave; the slave modport is the DUT view.
interface signal_flip_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/signal_flip_axil_slave.sv
// AXI4-Lite slave with four R/W registers driving a pattern that flips
// between PATTERN and ~PATTERN every PERIOD+1 cycles while enabled.
module signal_flip_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  signal_flip_axil_slave_if.slave       s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] flip_out,
  output logic                          flip_phase
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_PERIOD  = 2'd1,
    REG_PATTERN = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_idx_e;

  logic          init_q;
  logic          aw_lat_q, w_lat_q;
  logic [1:0]    awidx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          bvalid_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [DW-1:0] flip_q, flip_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_en, period_wr;
  logic unused_bits;

  // Ready stays low until the first clock edge after reset release.
  assign s_axi.AWREADY = init_q && !aw_lat_q && !bvalid_q;
  assign s_axi.WREADY  = init_q && !w_lat_q && !bvalid_q;
  assign s_axi.ARREADY = init_q && !rvalid_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;

  assign aw_hs     = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs      = s_axi.WVALID && s_axi.WREADY;
  assign b_hs      = bvalid_q && s_axi.BREADY;
  assign ar_hs     = s_axi.ARVALID && s_axi.ARREADY;
  assign r_hs      = rvalid_q && s_axi.RREADY;
  assign wr_en     = aw_lat_q && w_lat_q && !bvalid_q;
  assign period_wr = wr_en && (awidx_q == REG_PERIOD);

  assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q   <= 1'b0;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (b_hs) begin
        aw_lat_q <= 1'b0;
        w_lat_q  <= 1'b0;
        bvalid_q <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_lat_q <= 1'b1;
          awidx_q  <= s_axi.AWADDR[3:2];
        end
        if (w_hs) begin
          w_lat_q <= 1'b1;
          wdata_q <= s_axi.WDATA;
          wstrb_q <= s_axi.WSTRB;
        end
        if (wr_en) bvalid_q <= 1'b1;
      end
    end
  end

  // Read capture samples regs_q before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[s_axi.ARADDR[3:2]];
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  // NOTE: the register file is tiny and must read back zero after reset, so it is reset like any flop.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb_q[b]) regs_q[awidx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // NOTE: defaults first so every path assigns each output and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!regs_q[REG_CTRL][0]) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (period_wr) begin
      cnt_d = '0;
    end else if (cnt_q == regs_q[REG_PERIOD]) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    flip_d = phase_q ? ~regs_q[REG_PATTERN] : regs_q[REG_PATTERN];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      flip_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      flip_q  <= flip_d;
    end
  end

  assign flip_out   = flip_q;
  assign flip_phase = phase_q;
endmodule

// File: tb/tb_signal_flip_axil_slave.sv
// Directed bench for signal_flip_axil_slave: register access, handshake ordering,
// byte strobes, pattern flipping, read-during-write and reset of in-flight writes.
module tb_signal_flip_axil_slave;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] flip_out;
  logic        flip_phase;
  int          total = 0;
  int          bad = 0;

  signal_flip_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) s_axi ();

  signal_flip_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .s_axi     (s_axi),
    .flip_out  (flip_out),
    .flip_phase(flip_phase)
  );

  always #5 ACLK = ~ACLK;

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_hs, w_hs, done;
    @(negedge ACLK);
    s_axi.AWADDR = addr; s_axi.AWVALID = 1'b1;
    s_axi.WDATA = data;  s_axi.WSTRB = strb; s_axi.WVALID = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      aw_hs = s_axi.AWVALID && s_axi.AWREADY;
      w_hs  = s_axi.WVALID && s_axi.WREADY;
      @(negedge ACLK);
      if (aw_hs) s_axi.AWVALID = 1'b0;
      if (w_hs)  s_axi.WVALID = 1'b0;
      if (!s_axi.AWVALID && !s_axi.WVALID) begin done = 1'b1; break; end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wr_handshake addr=%h got=timeout expected=handshake", addr);
      s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
    end
    s_axi.BREADY = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_axi.BVALID) begin
        total++;
        if (s_axi.BRESP !== 2'b00) begin
          bad++; $display("FAIL bresp addr=%h got=%b expected=00", addr, s_axi.BRESP);
        end
        @(negedge ACLK);
        done = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    s_axi.BREADY = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL bvalid_wait addr=%h got=timeout expected=BVALID", addr); end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic done;
    data = 'x;
    @(negedge ACLK);
    s_axi.ARADDR = addr; s_axi.ARVALID = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_axi.ARREADY) begin @(negedge ACLK); done = 1'b1; break; end
      @(negedge ACLK);
    end
    s_axi.ARVALID = 1'b0;
    s_axi.RREADY = 1'b1;
    for (int c = 0; c < 20 && done; c++) begin
      if (s_axi.RVALID) begin
        data = s_axi.RDATA;
        total++;
        if (s_axi.RRESP !== 2'b00) begin
          bad++; $display("FAIL rresp addr=%h got=%b expected=00", addr, s_axi.RRESP);
        end
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
    end
    s_axi.RREADY = 1'b0;
    total++;
    if (data === 'x) begin bad++; $display("FAIL rd_handshake addr=%h got=timeout expected=RVALID", addr); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    total++;
    if ({s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY, s_axi.BVALID, s_axi.RVALID} !== 5'b0) begin
      bad++; $display("FAIL rst_handshake got=%b expected=00000",
                      {s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY, s_axi.BVALID, s_axi.RVALID});
    end
    total++;
    if ({flip_out, flip_phase, s_axi.RDATA} !== 65'b0) begin
      bad++; $display("FAIL rst_outputs got=%h/%b/%h expected=0/0/0", flip_out, flip_phase, s_axi.RDATA);
    end
    ARESETN = 1'b1;
    #1;
    total++;
    if ({s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY} !== 3'b000) begin
      bad++; $display("FAIL ready_before_edge got=%b expected=000", {s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY});
    end
    @(negedge ACLK);
    total++;
    if ({s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY} !== 3'b111) begin
      bad++; $display("FAIL ready_after_edge got=%b expected=111", {s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY});
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      total++;
      if (rd !== 32'(i + 1)) begin
        bad++; $display("FAIL basic_read reg=%0d got=%h expected=%h", i, rd, 32'(i + 1));
      end
    end
  endtask

  task automatic test_split_write();
    logic [31:0] rd;
    logic        ok;
    @(negedge ACLK);
    s_axi.WDATA = 32'hDEADBEEF; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1; s_axi.BREADY = 1'b0;
    @(negedge ACLK);
    s_axi.WVALID = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (s_axi.WREADY !== 1'b0 || s_axi.AWREADY !== 1'b1) begin
        bad++; $display("FAIL w_first_ready got=W%b/AW%b expected=W0/AW1", s_axi.WREADY, s_axi.AWREADY);
      end
      @(negedge ACLK);
    end
    s_axi.AWADDR = 4'hC; s_axi.AWVALID = 1'b1;
    @(negedge ACLK);
    s_axi.AWVALID = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (s_axi.BVALID) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL split_bvalid got=timeout expected=BVALID"); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({s_axi.BVALID, s_axi.BRESP, s_axi.AWREADY, s_axi.WREADY} !== 5'b10000) begin
        bad++; $display("FAIL b_hold cyc=%0d got=%b expected=10000", c,
                        {s_axi.BVALID, s_axi.BRESP, s_axi.AWREADY, s_axi.WREADY});
      end
      @(negedge ACLK);
    end
    s_axi.BREADY = 1'b1;
    @(negedge ACLK);
    s_axi.BREADY = 1'b0;
    total++;
    if ({s_axi.BVALID, s_axi.AWREADY, s_axi.WREADY} !== 3'b011) begin
      bad++; $display("FAIL b_release got=%b expected=011", {s_axi.BVALID, s_axi.AWREADY, s_axi.WREADY});
    end
    axi_read(4'hC, rd);
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL split_readback got=%h expected=deadbeef", rd); end
  endtask

  task automatic test_wstrb();
    logic [31:0] rd;
    axi_write(4'hC, 32'h11223344, 4'hF);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0010);
    axi_read(4'hC, rd);
    total++;
    if (rd !== 32'h1122CC44) begin bad++; $display("FAIL wstrb_byte1 got=%h expected=1122cc44", rd); end
    axi_write(4'hE, 32'hFFFFFFFF, 4'b0000);
    axi_read(4'hF, rd);
    total++;
    if (rd !== 32'h1122CC44) begin bad++; $display("FAIL wstrb_zero got=%h expected=1122cc44", rd); end
  endtask

  task automatic test_flip();
    logic [31:0] first, last, exp;
    logic        seen;
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h8, 32'h0000FFFF, 4'hF);
    axi_write(4'h4, 32'd3, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    last = flip_out;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (flip_out !== last) begin seen = 1'b1; break; end
    end
    first = flip_out;
    total++;
    if (!seen || (first !== 32'h0000FFFF && first !== 32'hFFFF0000)) begin
      bad++; $display("FAIL flip_start got=%h expected=0000ffff or ffff0000", first);
    end
    for (int k = 0; k < 12; k++) begin
      exp = ((k / 4) % 2 == 0) ? first : ~first;
      total++;
      if (flip_out !== exp) begin bad++; $display("FAIL flip_seq k=%0d got=%h expected=%h", k, flip_out, exp); end
      @(negedge ACLK);
    end
    axi_write(4'h0, 32'h0, 4'hF);
    repeat (3) @(negedge ACLK);
    total++;
    if (flip_out !== 32'h0000FFFF || flip_phase !== 1'b0) begin
      bad++; $display("FAIL flip_disabled got=%h/%b expected=0000ffff/0", flip_out, flip_phase);
    end
  endtask

  task automatic test_period_zero();
    logic p;
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    p = flip_phase;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      p = !p;
      total++;
      if (flip_phase !== p) begin bad++; $display("FAIL period0_toggle k=%0d got=%b expected=%b", k, flip_phase, p); end
    end
    axi_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_read_during_write();
    logic [31:0] rd;
    axi_write(4'h8, 32'h9, 4'hF);
    @(negedge ACLK);
    s_axi.AWADDR = 4'h8; s_axi.AWVALID = 1'b1;
    s_axi.WDATA = 32'h5;  s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
    @(negedge ACLK);
    s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
    s_axi.ARADDR = 4'h8;  s_axi.ARVALID = 1'b1;
    @(negedge ACLK);
    s_axi.ARVALID = 1'b0;
    total++;
    if ({s_axi.RVALID, s_axi.BVALID} !== 2'b11 || s_axi.RDATA !== 32'h9) begin
      bad++; $display("FAIL raw_old_value got=R%b/B%b/%h expected=R1/B1/00000009",
                      s_axi.RVALID, s_axi.BVALID, s_axi.RDATA);
    end
    s_axi.RREADY = 1'b1; s_axi.BREADY = 1'b1;
    @(negedge ACLK);
    s_axi.RREADY = 1'b0; s_axi.BREADY = 1'b0;
    axi_read(4'h8, rd);
    total++;
    if (rd !== 32'h5) begin bad++; $display("FAIL raw_new_value got=%h expected=00000005", rd); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd;
    logic        ok;
    @(negedge ACLK);
    s_axi.AWADDR = 4'hC; s_axi.AWVALID = 1'b1;
    @(negedge ACLK);
    s_axi.AWVALID = 1'b0;
    ok = (s_axi.AWREADY === 1'b0);
    ARESETN = 1'b0;
    #1;
    total++;
    if (!ok || {s_axi.AWREADY, s_axi.BVALID, flip_out} !== 34'b0) begin
      bad++; $display("FAIL inflight_reset got=aw_latched%b/AW%b/B%b/%h expected=1/0/0/0",
                      ok, s_axi.AWREADY, s_axi.BVALID, flip_out);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge ACLK);
      if (s_axi.BVALID !== 1'b0 || s_axi.AWREADY !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL inflight_discard got=BVALID or AWREADY wrong expected=B0/AW1"); end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_reg reg=%0d got=%h expected=0", i, rd); end
    end
  endtask

  initial begin
    s_axi.AWADDR = '0; s_axi.AWPROT = '0; s_axi.AWVALID = 1'b0;
    s_axi.WDATA = '0;  s_axi.WSTRB = '0;  s_axi.WVALID = 1'b0;
    s_axi.BREADY = 1'b0;
    s_axi.ARADDR = '0; s_axi.ARPROT = '0; s_axi.ARVALID = 1'b0;
    s_axi.RREADY = 1'b0;
    test_reset();
    test_basic_rw();
    test_split_write();
    test_wstrb();
    test_flip();
    test_period_zero();
    test_read_during_write();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=still running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
